// File: rtl/sbn_core.sv
// sbn_core: subtract-and-branch-if-negative machine with private instruction and
// data memories, host load port, single-step control and a data-write trace port.
module sbn_core #(
  parameter int FWIDTH = 8,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16,
  parameter int IWIDTH = 4*FWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              load_we,
  input  logic              load_sel,
  input  logic [FWIDTH-1:0] load_addr,
  input  logic [IWIDTH-1:0] load_idata,
  input  logic [DWIDTH-1:0] load_ddata,
  input  logic [FWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic [2:0]        state,
  output logic [FWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] a,
  output logic [DWIDTH-1:0] b,
  output logic              halted,
  output logic              busy,
  output logic [CWIDTH-1:0] icount,
  output logic              wr_valid,
  output logic [FWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data
);

  localparam int DEPTH = 1 << FWIDTH;
  localparam logic [FWIDTH-1:0] PC_ONE     = {{(FWIDTH-1){1'b0}}, 1'b1};
  localparam logic [CWIDTH-1:0] CNT_ONE    = {{(CWIDTH-1){1'b0}}, 1'b1};
  localparam logic [CWIDTH-1:0] ICOUNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_FETCH = 3'b001,
    S_RDA   = 3'b010,
    S_RDB   = 3'b011,
    S_WB    = 3'b100,
    S_TAKE  = 3'b101,
    S_SEQ   = 3'b110,
    S_HALT  = 3'b111
  } state_t;

  state_t cur, nxt;

  logic [IWIDTH-1:0] ir;
  logic [IWIDTH-1:0] imem [DEPTH];
  logic [DWIDTH-1:0] dmem [DEPTH];

  logic [FWIDTH-1:0] fa, fb, fc, fd;
  logic [DWIDTH-1:0] diff;
  logic              c_halt;
  logic              host_ok;

  assign fa     = ir[4*FWIDTH-1 -: FWIDTH];
  assign fb     = ir[3*FWIDTH-1 -: FWIDTH];
  assign fc     = ir[2*FWIDTH-1 -: FWIDTH];
  assign fd     = ir[FWIDTH-1:0];
  assign diff   = a - b;
  assign c_halt = &fc;

  // Host writes only land while the core is parked; rst wins over the strobe.
  assign host_ok = load_we && !rst && (cur == S_IDLE || cur == S_HALT);

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:         if (start) nxt = S_FETCH;
      S_FETCH:        nxt = S_RDA;
      S_RDA:          nxt = S_RDB;
      S_RDB:          nxt = c_halt ? S_HALT : S_WB;
      S_WB:           nxt = diff[DWIDTH-1] ? S_TAKE : S_SEQ;
      S_TAKE, S_SEQ:  nxt = step_mode ? S_IDLE : S_FETCH;
      S_HALT:         nxt = S_HALT;
      default:        nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur    <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      halted <= 1'b0;
      icount <= '0;
    end else begin
      cur <= nxt;
      case (cur)
        S_FETCH: ir <= imem[pc];
        S_RDA:   a  <= dmem[fa];
        S_RDB: begin
          b <= dmem[fb];
          if (c_halt) halted <= 1'b1;
        end
        S_TAKE, S_SEQ: begin
          pc <= (cur == S_TAKE) ? fd : pc + PC_ONE;
          if (icount != ICOUNT_MAX) icount <= icount + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Memories have no reset; a write pending in WB is dropped when rst is sampled.
  always_ff @(posedge clk) begin
    if (!rst && cur == S_WB) begin
      dmem[fc] <= diff;
    end else if (host_ok && load_sel) begin
      dmem[load_addr] <= load_ddata;
    end
  end

  always_ff @(posedge clk) begin
    if (host_ok && !load_sel) imem[load_addr] <= load_idata;
  end

  assign rd_data = dmem[rd_addr];
  assign state   = cur;
  assign busy    = (cur != S_IDLE) && (cur != S_HALT);

  // Trace port: wr_valid is a one-cycle strobe with no ready; wr_addr/wr_data are
  // meaningful only while it is high and describe the dmem write at this cycle's end.
  assign wr_valid = (cur == S_WB);
  assign wr_addr  = fc;
  assign wr_data  = diff;

endmodule

// File: tb/tb_sbn_core.sv
// Bench for sbn_core: instruction-level reference model with per-cycle output checks,
// a trace-write scoreboard and hand-computed directed expectations.
module tb_sbn_core;
  localparam int FW = 8;
  localparam int DW = 32;
  localparam int IW = 32;
  localparam int P_IDLE = -1;
  localparam int P_HALT = -2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          step_mode = 1'b0;
  logic          load_we = 1'b0;
  logic          load_sel = 1'b0;
  logic [FW-1:0] load_addr = '0;
  logic [IW-1:0] load_idata = '0;
  logic [DW-1:0] load_ddata = '0;
  logic [FW-1:0] rd_addr = '0;

  logic [DW-1:0] rd_data, a, b, wr_data;
  logic [2:0]    state;
  logic [FW-1:0] pc, wr_addr;
  logic          halted, busy, wr_valid;
  logic [15:0]   icount;

  logic [DW-1:0] s_rd_data, s_a, s_b, s_wr_data;
  logic [2:0]    s_state;
  logic [FW-1:0] s_pc, s_wr_addr;
  logic          s_halted, s_busy, s_wr_valid;
  logic [1:0]    s_icount;

  sbn_core dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode),
    .load_we(load_we), .load_sel(load_sel), .load_addr(load_addr),
    .load_idata(load_idata), .load_ddata(load_ddata), .rd_addr(rd_addr),
    .rd_data(rd_data), .state(state), .pc(pc), .a(a), .b(b),
    .halted(halted), .busy(busy), .icount(icount),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  sbn_core #(.CWIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode),
    .load_we(load_we), .load_sel(load_sel), .load_addr(load_addr),
    .load_idata(load_idata), .load_ddata(load_ddata), .rd_addr(rd_addr),
    .rd_data(s_rd_data), .state(s_state), .pc(s_pc), .a(s_a), .b(s_b),
    .halted(s_halted), .busy(s_busy), .icount(s_icount),
    .wr_valid(s_wr_valid), .wr_addr(s_wr_addr), .wr_data(s_wr_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one instruction at a time, tracked by cycles into the instruction
  int            ph = P_IDLE;
  int            retired = 0;
  logic [FW-1:0] m_pc = '0;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic [DW-1:0] m_dmem [256];
  logic [IW-1:0] m_imem [256];
  bit            m_dv [256];
  logic [IW-1:0] ins;
  logic [FW-1:0] cur_c, cur_d;
  logic [DW-1:0] cur_x, cur_y, cur_r;
  logic [FW+DW-1:0] exp_q[$];
  logic [FW+DW-1:0] e;

  task automatic m_decode();
    ins   = m_imem[m_pc];
    cur_x = m_dmem[ins[31:24]];
    cur_y = m_dmem[ins[23:16]];
    cur_c = ins[15:8];
    cur_d = ins[7:0];
    cur_r = cur_x - cur_y;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      ph = P_IDLE; m_pc = '0; retired = 0; m_a = '0; m_b = '0;
      exp_q.delete();
    end else begin
      case (ph)
        P_IDLE, P_HALT: begin
          if (load_we) begin
            if (load_sel) begin m_dmem[load_addr] = load_ddata; m_dv[load_addr] = 1'b1; end
            else m_imem[load_addr] = load_idata;
          end
          if (ph == P_IDLE && start) begin m_decode(); ph = 0; end
        end
        0: ph = 1;
        1: begin m_a = cur_x; ph = 2; end
        2: begin
          m_b = cur_y;
          if (cur_c == 8'hFF) ph = P_HALT;
          else begin ph = 3; exp_q.push_back({cur_c, cur_r}); end
        end
        3: begin m_dmem[cur_c] = cur_r; m_dv[cur_c] = 1'b1; ph = 4; end
        4: begin
          m_pc = cur_r[DW-1] ? cur_d : m_pc + 8'd1;
          retired++;
          if (step_mode) ph = P_IDLE;
          else begin m_decode(); ph = 0; end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  function automatic logic [2:0] exp_state();
    case (ph)
      P_IDLE:  return 3'd0;
      P_HALT:  return 3'd7;
      0:       return 3'd1;
      1:       return 3'd2;
      2:       return 3'd3;
      3:       return 3'd4;
      default: return cur_r[DW-1] ? 3'd5 : 3'd6;
    endcase
  endfunction

  // scoreboard / per-cycle compare
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", state, exp_state());
      check("state_sat", s_state, exp_state());
      check("pc", pc, m_pc);
      check("icount", icount, (retired > 65535) ? 65535 : retired);
      check("icount_sat", s_icount, (retired > 3) ? 3 : retired);
      check("halted", halted, ph == P_HALT);
      check("busy", busy, ph >= 0);
      check("a", a, m_a);
      check("b", b, m_b);
      check("wr_valid", wr_valid, ph == 3);
      if (wr_valid) begin
        if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[FW+DW-1:DW]);
          check("wr_data", wr_data, e[DW-1:0]);
        end
      end
      if (m_dv[rd_addr]) check("rd_data", rd_data, m_dmem[rd_addr]);
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic load_i(input logic [FW-1:0] ad, input logic [IW-1:0] d);
    @(negedge clk);
    load_we = 1'b1; load_sel = 1'b0; load_addr = ad; load_idata = d;
    @(negedge clk) load_we = 1'b0;
  endtask

  task automatic load_d(input logic [FW-1:0] ad, input logic [DW-1:0] d);
    @(negedge clk);
    load_we = 1'b1; load_sel = 1'b1; load_addr = ad; load_ddata = d;
    @(negedge clk) load_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic peek(input string name, input logic [FW-1:0] ad, input logic [DW-1:0] exp);
    rd_addr = ad;
    #1 check(name, rd_data, exp);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (state !== s && n < budget) begin @(negedge clk); n++; end
    check("wait_state", state, s);
  endtask

  int n;

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_state", state, 0);  check("rst_pc", pc, 0);
    check("rst_a", a, 0);          check("rst_b", b, 0);
    check("rst_halted", halted, 0); check("rst_icount", icount, 0);
    check("rst_busy", busy, 0);    check("rst_wr_valid", wr_valid, 0);

    // taken branch, step mode so the core parks afterwards
    step_mode = 1'b1;
    load_i(8'h00, 32'h0A0B0C05);
    load_d(8'h0A, 32'd3);
    load_d(8'h0B, 32'd7);
    pulse_start();
    check("fetch_state", state, 1);
    repeat (3) @(negedge clk);
    check("taken_wr_valid", wr_valid, 1);
    check("taken_wr_addr", wr_addr, 8'h0C);
    check("taken_wr_data", wr_data, 32'hFFFFFFFC);
    @(negedge clk) check("taken_state", state, 5);
    @(negedge clk);
    check("taken_pc", pc, 8'h05);
    check("taken_icount", icount, 1);

    // not taken, then equal operands
    do_reset();
    load_d(8'h0A, 32'd7);
    load_d(8'h0B, 32'd3);
    pulse_start();
    repeat (5) @(negedge clk);
    check("nt_pc", pc, 8'h01);
    peek("nt_rd", 8'h0C, 32'h00000004);
    do_reset();
    load_d(8'h0A, 32'd5);
    load_d(8'h0B, 32'd5);
    pulse_start();
    repeat (5) @(negedge clk);
    check("eq_pc", pc, 8'h01);
    peek("eq_rd", 8'h0C, 32'h00000000);

    // halt
    do_reset();
    load_i(8'h00, 32'h0A0BFF00);
    pulse_start();
    repeat (2) @(negedge clk);
    check("halt_rdb_halted", halted, 0);
    @(negedge clk);
    check("halt_state", state, 7);
    check("halt_halted", halted, 1);
    check("halt_icount", icount, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    check("halt_sticky", state, 7);
    load_d(8'h40, 32'h1234);
    peek("halt_load", 8'h40, 32'h1234);

    // two-instruction program in step mode, second reads the first's result
    do_reset();
    load_i(8'h00, 32'h0A0B0C00);
    load_i(8'h01, 32'h0C0B0D00);
    load_d(8'h0A, 32'd7);
    load_d(8'h0B, 32'd3);
    pulse_start();
    repeat (5) @(negedge clk);
    check("step1_state", state, 0);
    check("step1_icount", icount, 1);
    repeat (4) @(negedge clk);
    check("step_wait_icount", icount, 1);
    pulse_start();
    repeat (5) @(negedge clk);
    check("step2_icount", icount, 2);
    check("step2_pc", pc, 8'h02);
    peek("step2_rd", 8'h0D, 32'd1);

    // pc wrap: branch to FF, then fall through to 00
    do_reset();
    load_i(8'h00, 32'h0B0A0CFF);
    load_i(8'hFF, 32'h0A0B0E00);
    pulse_start();
    repeat (5) @(negedge clk);
    check("wrap_pc_ff", pc, 8'hFF);
    pulse_start();
    repeat (5) @(negedge clk);
    check("wrap_pc_00", pc, 8'h00);
    peek("wrap_rd", 8'h0E, 32'd4);

    // continuous run of five instructions then halt; CWIDTH=2 copy saturates
    step_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) load_i(8'(i), {8'h0A, 8'h0B, 8'(8'h20 + i), 8'h00});
    load_i(8'h05, 32'h0A0BFF00);
    pulse_start();
    wait_state(3'd7, 200, n);
    check("cont_cycles", n, 28);
    check("cont_icount", icount, 5);
    check("cont_icount_sat", s_icount, 3);
    check("cont_pc", pc, 8'h05);
    peek("cont_rd", 8'h24, 32'd4);

    // reset while in WB drops the write; host load during FETCH is ignored
    step_mode = 1'b1;
    do_reset();
    load_i(8'h00, 32'h0A0B0C00);
    load_d(8'h0C, 32'h55);
    load_d(8'h30, 32'h11);
    pulse_start();
    wait_state(3'd4, 10, n);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("mid_state", state, 0);
    check("mid_wr_valid", wr_valid, 0);
    check("mid_pc", pc, 0);
    check("mid_a", a, 0);
    peek("mid_rd", 8'h0C, 32'h55);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_we = 1'b1; load_sel = 1'b1; load_addr = 8'h30; load_ddata = 32'h99;
    @(negedge clk) load_we = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_load_state", state, 0);
    peek("busy_load_rd", 8'h30, 32'h11);
    peek("after_mid_rd", 8'h0C, 32'h4);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
